pci_dma_master: RTL and testbench

- User-side PCI initiator engine; drives the core's master interface that the memory target app currently ties off (request, m_cbe, m_wrdn, complete, m_ready, int_n).
- Moves a block of dwords between a local show-ahead FIFO pair and host memory in bursts of up to MAX_BURST dwords.
- Splits long transfers into bursts and resumes after target disconnect or retry.
- Runs in the 66 MHz PCI user clock domain, beside the target logic.

---
 rtl/pci_dma_master.sv | 155 +++++++++++++++
 tb/tb_pci_dma_master.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pci_dma_master.sv
// pci_dma_master: PCI initiator engine moving dword blocks between local
// FIFOs and host memory in bursts that never cross a 4 KB page.
module pci_dma_master #(
    parameter int MAX_BURST = 16,
    parameter int LEN_W     = 16,
    parameter int RETRY_MAX = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dir,
    input  logic [31:0]      pci_addr,
    input  logic [LEN_W-1:0] xfer_len,
    input  logic             int_en,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             request,
    output logic             m_wrdn,
    output logic [3:0]       m_cbe,
    output logic             m_ready,
    output logic             complete,
    output logic [31:0]      adio_in,
    output logic             int_n,
    input  logic             m_addr_n,
    input  logic             m_data,
    input  logic             m_data_vld,
    input  logic [31:0]      adio_out,
    input  logic             mst_abort,
    input  logic             tgt_abort,
    input  logic             tgt_term,
    input  logic [31:0]      src_data,
    input  logic             src_empty,
    output logic             src_rd,
    output logic [31:0]      dst_data,
    output logic             dst_wr,
    input  logic             dst_full
);
    localparam int BW = $clog2(MAX_BURST) + 1;
    localparam int RW = $clog2(RETRY_MAX + 1);

    typedef enum logic [2:0] {
        IDLE, REQ, ADDR, DATA, ERR, DONE
    } state_t;

    state_t           state, state_nx;
    logic [31:0]      cur_addr;
    logic [LEN_W-1:0] remaining, rem_nx;
    logic [BW-1:0]    burst, beats, lim;
    logic [RW-1:0]    retries;
    logic [10:0]      page_left;
    logic             dir_q, int_en_q, aborted, m_data_q;
    logic             beat, txn_end, abort_hit, zero_txn;
    logic             unused_ok;

    // Disconnect and retry both just end the transaction; resume is generic.
    assign unused_ok = tgt_term ^ (^pci_addr[1:0]);

    assign page_left = 11'd1024 - {1'b0, cur_addr[11:2]};
    assign beat      = (state == DATA) && m_data_vld && (remaining != '0);
    assign txn_end   = (state == DATA) && m_data_q && !m_data;
    assign abort_hit = aborted || tgt_abort || mst_abort;
    assign zero_txn  = (beats == '0) && !beat;
    assign rem_nx    = remaining - LEN_W'(beat);

    always_comb begin
        lim = BW'(MAX_BURST);
        if (32'(remaining) < 32'(MAX_BURST)) lim = BW'(remaining);
        if (32'(page_left) < 32'(lim)) lim = BW'(page_left);
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (start) state_nx = (xfer_len == '0) ? DONE : REQ;
            REQ:  state_nx = ADDR;
            ADDR: if (!m_addr_n) state_nx = DATA;
            DATA: begin
                if (txn_end) begin
                    if (abort_hit)
                        state_nx = ERR;
                    else if (rem_nx == '0)
                        state_nx = DONE;
                    else if (zero_txn && retries >= RW'(RETRY_MAX - 1))
                        state_nx = ERR;
                    else
                        state_nx = REQ;
                end
            end
            ERR:  state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cur_addr  <= '0;
            remaining <= '0;
            burst     <= '0;
            beats     <= '0;
            retries   <= '0;
            dir_q     <= 1'b0;
            int_en_q  <= 1'b0;
            aborted   <= 1'b0;
            m_data_q  <= 1'b0;
            err       <= 1'b0;
            int_n     <= 1'b1;
        end else begin
            state    <= state_nx;
            m_data_q <= m_data;
            if (state == IDLE && start) begin
                cur_addr  <= {pci_addr[31:2], 2'b00};
                remaining <= xfer_len;
                dir_q     <= dir;
                int_en_q  <= int_en;
                err       <= 1'b0;
                retries   <= '0;
                int_n     <= !(int_en && xfer_len == '0);
            end else if (state_nx == DONE && int_en_q) begin
                int_n <= 1'b0;
            end
            if (state == REQ) begin
                burst   <= lim;
                beats   <= '0;
                aborted <= 1'b0;
            end
            if ((state == ADDR || state == DATA) && (tgt_abort || mst_abort))
                aborted <= 1'b1;
            if (beat) begin
                beats     <= beats + BW'(1);
                cur_addr  <= cur_addr + 32'd4;
                remaining <= rem_nx;
                retries   <= '0;
            end else if (txn_end && zero_txn && !abort_hit) begin
                retries <= retries + RW'(1);
            end
            if (state == ERR) err <= 1'b1;
        end
    end

    assign request  = (state == REQ);
    assign m_cbe    = (state == REQ) ? {3'b011, dir_q} : 4'b0000;
    assign m_wrdn   = (state != IDLE) && dir_q;
    assign adio_in  = (state == ADDR && !m_addr_n) ? cur_addr :
                      (state == DATA && dir_q)     ? src_data : '0;
    assign m_ready  = (state == DATA) && (dir_q ? !src_empty : !dst_full);
    assign complete = (state == DATA) && (beats >= burst - BW'(1));
    assign src_rd   = beat && dir_q;
    assign dst_wr   = beat && !dir_q;
    assign dst_data = dst_wr ? adio_out : '0;
    assign busy     = (state != IDLE) && (state != DONE);
    assign done     = (state == DONE);
endmodule

// File: tb/tb_pci_dma_master.sv
// Bench for pci_dma_master: PCI core and FIFO models around the DUT with a
// burst-level reference model compared on every cycle.
`timescale 1ns/1ps
module tb_pci_dma_master;
    localparam int MAXB = 16;
    localparam int LW   = 16;

    logic          clk, rst, start, dir, int_en;
    logic [31:0]   pci_addr;
    logic [LW-1:0] xfer_len;
    logic          busy, done, err, request, m_wrdn, m_ready, complete, int_n;
    logic [3:0]    m_cbe;
    logic [31:0]   adio_in, adio_out, src_data, dst_data;
    logic          m_addr_n, m_data, m_data_vld, mst_abort, tgt_abort, tgt_term;
    logic          src_empty, src_rd, dst_wr, dst_full;

    pci_dma_master #(.MAX_BURST(MAXB), .LEN_W(LW), .RETRY_MAX(255)) dut (
        .clk(clk), .rst(rst), .start(start), .dir(dir), .pci_addr(pci_addr),
        .xfer_len(xfer_len), .int_en(int_en), .busy(busy), .done(done),
        .err(err), .request(request), .m_wrdn(m_wrdn), .m_cbe(m_cbe),
        .m_ready(m_ready), .complete(complete), .adio_in(adio_in),
        .int_n(int_n), .m_addr_n(m_addr_n), .m_data(m_data),
        .m_data_vld(m_data_vld), .adio_out(adio_out), .mst_abort(mst_abort),
        .tgt_abort(tgt_abort), .tgt_term(tgt_term), .src_data(src_data),
        .src_empty(src_empty), .src_rd(src_rd), .dst_data(dst_data),
        .dst_wr(dst_wr), .dst_full(dst_full)
    );

    int n_chk = 0, n_fail = 0;
    // reference model of the descriptor in flight
    bit          m_dir, mon_on, bfm_on, rnd_mode, abort_next, hide;
    logic [31:0] m_base, m_seed, exp_addr;
    int          m_len, m_done, txn_burst, txn_beats, pg;
    int          n_req, n_srd, n_dwr, full_seen, done_cnt;
    int          retry_left, disc_at, full_at, src_cnt;
    logic [31:0] src_q[$];
    logic [31:0] obs_addr[$];
    int          obs_len[$];

    assign src_empty = (src_cnt == 0) || hide;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] rd_pat(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hA5C3_3C5A;
    endfunction

    always @(negedge clk) begin
        if (mon_on) begin
            if (request) begin
                chk("req_cbe", 32'(m_cbe), m_dir ? 32'd7 : 32'd6);
                chk("req_wrdn", 32'(m_wrdn), 32'(m_dir));
                exp_addr  = m_base + 32'(m_done) * 32'd4;
                txn_burst = m_len - m_done;
                if (txn_burst > MAXB) txn_burst = MAXB;
                pg = (4096 - int'(exp_addr[11:0])) / 4;
                if (txn_burst > pg) txn_burst = pg;
                txn_beats = 0;
                n_req++;
            end
            if (!m_addr_n) begin
                chk("addr", adio_in, exp_addr);
                obs_addr.push_back(adio_in);
                obs_len.push_back(0);
            end
            if (m_data)
                chk("m_ready", 32'(m_ready), 32'(m_dir ? !src_empty : !dst_full));
            if (m_data && !m_dir && dst_full && !m_ready) full_seen++;
            if (m_data && m_data_vld) begin
                chk("complete", 32'(complete), 32'(txn_beats == txn_burst - 1));
                if (m_dir) begin
                    chk("src_rd", 32'(src_rd), 1);
                    chk("wr_data", adio_in, m_seed + 32'(m_done));
                    void'(src_q.pop_front());
                    src_data = (src_q.size() > 0) ? src_q[0] : 32'd0;
                    src_cnt  = src_q.size();
                end else begin
                    chk("dst_wr", 32'(dst_wr), 1);
                    chk("rd_data", dst_data, rd_pat(exp_addr + 32'(txn_beats) * 32'd4));
                end
                txn_beats++;
                m_done++;
                if (obs_len.size() > 0)
                    obs_len[obs_len.size()-1] = obs_len[obs_len.size()-1] + 1;
            end else begin
                chk("no_xfer", 32'({src_rd, dst_wr}), 0);
            end
            if (src_rd) n_srd++;
            if (dst_wr) n_dwr++;
            if (done) begin
                chk("busy_in_done", 32'(busy), 0);
                done_cnt++;
            end
        end
    end

    // PCI core model: address phase, data beats, terminations
    initial begin : bfm
        int beat, dz, fcyc;
        bit fin;
        logic [31:0] ba;
        m_addr_n = 1; m_data = 0; m_data_vld = 0; adio_out = 0;
        mst_abort = 0; tgt_abort = 0; tgt_term = 0; dst_full = 0; hide = 0;
        forever begin
            @(posedge clk); #1;
            if (request && bfm_on) begin
                @(posedge clk); #1;
                m_addr_n = 0;
                #1 ba = adio_in;
                @(posedge clk); #1;
                m_addr_n = 1; m_data = 1; beat = 0; fin = 0; fcyc = 0;
                dz = (rnd_mode && $urandom_range(0, 3) == 0) ?
                     int'($urandom_range(1, 6)) : disc_at;
                disc_at = 0;
                while (!fin) begin
                    hide = rnd_mode && ($urandom_range(0, 3) == 0);
                    dst_full = hide;
                    if (full_at >= 0 && beat == full_at) begin
                        dst_full = 1;
                        fcyc++;
                        if (fcyc == 3) full_at = -1;
                    end
                    if (abort_next) begin
                        mst_abort = 1; abort_next = 0; fin = 1;
                    end else if (beat == 0 && (retry_left > 0 ||
                                 (rnd_mode && $urandom_range(0, 7) == 0))) begin
                        tgt_term = 1; fin = 1;
                        if (retry_left > 0) retry_left--;
                    end else begin
                        adio_out = rd_pat(ba + 32'(beat) * 32'd4);
                        #1 m_data_vld = m_ready;
                        if (m_data_vld) begin
                            beat++;
                            if (complete) fin = 1;
                            if (beat == dz) begin tgt_term = 1; fin = 1; end
                        end
                    end
                    @(posedge clk); #1;
                    m_data_vld = 0; tgt_term = 0; mst_abort = 0;
                    hide = 0; dst_full = 0;
                end
                m_data = 0;
            end
        end
    end

    task automatic kick(input bit d, input logic [31:0] a, input int len, input bit ie);
        @(posedge clk); #1;
        start = 1; dir = d; pci_addr = a; xfer_len = LW'(len); int_en = ie;
        @(posedge clk); #1;
        start = 0; dir = ~d; pci_addr = $urandom; xfer_len = LW'($urandom); int_en = ~ie;
    endtask

    task automatic setup(input bit d, input logic [31:0] a, input int len);
        m_dir = d; m_base = {a[31:2], 2'b00}; m_len = len; m_done = 0;
        m_seed = $urandom;
        src_q.delete();
        if (d) for (int k = 0; k < len; k++) src_q.push_back(m_seed + 32'(k));
        src_data = (src_q.size() > 0) ? src_q[0] : 32'd0;
        src_cnt = src_q.size();
        obs_addr.delete(); obs_len.delete();
        n_req = 0; n_srd = 0; n_dwr = 0; full_seen = 0;
    endtask

    task automatic run(input bit d, input logic [31:0] a, input int len,
                       input bit ie, input bit exp_err);
        int d0;
        setup(d, a, len);
        d0 = done_cnt;
        kick(d, a, len, ie);
        @(negedge clk); #1;
        chk("busy_after_start", 32'(busy), 32'(len != 0));
        chk("err_cleared", 32'(err), 0);
        chk("int_n_cleared", 32'(int_n), 32'(!(ie && len == 0)));
        for (int c = 0; c < 6000 && done_cnt == d0; c++) begin
            @(negedge clk); #1;
        end
        chk("done_seen", 32'(done_cnt != d0), 1);
        chk("err_final", 32'(err), 32'(exp_err));
        chk("int_n_final", 32'(int_n), 32'(!ie));
        if (!exp_err) chk("beats_total", 32'(m_done), 32'(len));
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        rst = 1; start = 0; dir = 0; pci_addr = 0; xfer_len = 0; int_en = 0;
        mon_on = 0; bfm_on = 1; rnd_mode = 0; abort_next = 0;
        retry_left = 0; disc_at = 0; full_at = -1; src_cnt = 0; src_data = 0;
        done_cnt = 0;
        #2;
        chk("reset_ctl", 32'({request, m_wrdn, m_cbe, m_ready, complete, busy,
                              done, err, int_n, src_rd, dst_wr}), 32'h0004);
        chk("reset_adio", adio_in, 0);
        chk("reset_dst", dst_data, 0);
        #20 rst = 0;
        mon_on = 1;

        run(1, 32'h1000_0000, 8, 0, 0);
        chk("t1_nreq", 32'(n_req), 1);
        chk("t1_srd", 32'(n_srd), 8);
        chk("t1_len", 32'(obs_len[0]), 8);

        run(0, 32'h2000_0002, 40, 0, 0);
        chk("t2_nreq", 32'(n_req), 3);
        chk("t2_a0", obs_addr[0], 32'h2000_0000);
        chk("t2_a1", obs_addr[1], 32'h2000_0040);
        chk("t2_a2", obs_addr[2], 32'h2000_0080);
        chk("t2_l2", 32'(obs_len[2]), 8);
        chk("t2_dwr", 32'(n_dwr), 40);

        disc_at = 5;
        run(1, 32'h4000_0100, 16, 0, 0);
        chk("t3_a1", obs_addr[1], 32'h4000_0114);
        chk("t3_l0", 32'(obs_len[0]), 5);
        chk("t3_l1", 32'(obs_len[1]), 11);

        abort_next = 1;
        run(0, 32'h3000_0000, 8, 1, 1);
        chk("t4_nreq", 32'(n_req), 1);
        run(1, 32'h5000_0000, 4, 0, 0);

        run(0, 32'h0000_0FF8, 10, 0, 0);
        chk("t5_a0", obs_addr[0], 32'h0000_0FF8);
        chk("t5_a1", obs_addr[1], 32'h0000_1000);
        chk("t5_l0", 32'(obs_len[0]), 2);
        chk("t5_l1", 32'(obs_len[1]), 8);

        full_at = 4;
        run(0, 32'h6000_0000, 16, 0, 0);
        chk("t6_full", 32'(full_seen), 3);
        chk("t6_dwr", 32'(n_dwr), 16);

        retry_left = 3;
        run(0, 32'h6100_0000, 8, 0, 0);
        chk("t7_nreq", 32'(n_req), 4);
        chk("t7_l3", 32'(obs_len[3]), 8);

        retry_left = 255;
        run(0, 32'h6200_0000, 8, 1, 1);
        chk("t8_nreq", 32'(n_req), 255);

        run(0, 32'h8000_0000, 0, 1, 0);
        chk("t9_nreq", 32'(n_req), 0);

        run(1, 32'hFFFF_FFF8, 6, 0, 0);
        chk("t10_a1", obs_addr[1], 32'h0000_0000);
        chk("t10_l1", 32'(obs_len[1]), 4);

        rnd_mode = 1;
        for (int i = 0; i < 20; i++) begin
            logic [31:0] ra;
            ra = $urandom;
            if ($urandom_range(0, 1) == 1) ra[11:0] = 12'hFC0 + 12'($urandom_range(0, 15) * 4);
            run(1'($urandom_range(0, 1)), ra, int'($urandom_range(0, 40)),
                1'($urandom_range(0, 1)), 0);
        end
        rnd_mode = 0;

        setup(0, 32'h7000_0000, 32);
        kick(0, 32'h7000_0000, 32, 1);
        for (int c = 0; c < 2000 && m_done < 5; c++) @(negedge clk);
        chk("rst_mid_reached", 32'(m_done >= 5), 1);
        @(negedge clk);
        mon_on = 0; bfm_on = 0; rst = 1;
        #1;
        chk("rst_mid_ctl", 32'({request, m_wrdn, m_cbe, m_ready, complete, busy,
                                done, err, int_n, src_rd, dst_wr}), 32'h0004);
        chk("rst_mid_adio", adio_in, 0);
        @(posedge clk); #1;
        chk("rst_edge_ctl", 32'({request, m_wrdn, m_cbe, m_ready, complete, busy,
                                 done, err, int_n, src_rd, dst_wr}), 32'h0004);
        chk("rst_edge_dst", dst_data, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
